// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
package mdu_pkg;

   typedef enum logic [1:0] {
      MDU_MULTU = 2'b00,
      MDU_MULT  = 2'b01,
      MDU_DIVU  = 2'b10,
      MDU_DIV   = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } mdu_state_e;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negation, truncated to W bits.
module mdu_negate #(
   parameter int unsigned W = 32
) (
   input  logic         neg_i,
   input  logic [W-1:0] in_i,
   output logic [W-1:0] out_o
);

   assign out_o = neg_i ? (~in_i + 1'b1) : in_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// signs handled by magnitude operands plus a final correction step.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             div_by_zero_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned W2    = 2 * WIDTH;
   localparam logic [CNT_W-1:0] CntInit = CNT_W'(WIDTH);

   mdu_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [W2-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]  opnd_q, opnd_d;
   logic              is_div_q, is_div_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_rem_q, neg_rem_d;
   logic              dbz_q, dbz_d;
   logic              dbz_flag_q, dbz_flag_d;
   logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;

   logic [WIDTH-1:0]  a_abs, b_abs, quot_fix, rem_fix;
   logic [W2-1:0]     prod_fix, mul_next, div_next;
   logic [WIDTH:0]    mul_sum, rem_sh, trial;

   mdu_negate #(.W(WIDTH)) u_abs_a (.neg_i(op_i[0] & a_i[WIDTH-1]), .in_i(a_i), .out_o(a_abs));
   mdu_negate #(.W(WIDTH)) u_abs_b (.neg_i(op_i[0] & b_i[WIDTH-1]), .in_i(b_i), .out_o(b_abs));
   mdu_negate #(.W(W2))    u_fix_p (.neg_i(neg_res_q), .in_i(acc_q), .out_o(prod_fix));
   mdu_negate #(.W(WIDTH)) u_fix_q (.neg_i(neg_res_q), .in_i(acc_q[WIDTH-1:0]), .out_o(quot_fix));
   mdu_negate #(.W(WIDTH)) u_fix_r (.neg_i(neg_rem_q), .in_i(acc_q[W2-1:WIDTH]), .out_o(rem_fix));

   // Multiply: acc = {partial product, remaining multiplier bits}.
   assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: acc = {partial remainder, dividend bits / quotient bits}; borrow restores.
   assign rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
   assign trial    = rem_sh - {1'b0, opnd_q};
   assign div_next = {(trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], ~trial[WIDTH]};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      is_div_d   = is_div_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      dbz_d      = dbz_q;
      dbz_flag_d = dbz_flag_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d    = RUN;
               cnt_d      = CntInit;
               is_div_d   = op_i[1];
               neg_res_d  = op_i[0] & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
               neg_rem_d  = op_i[0] & a_i[WIDTH-1];
               dbz_d      = op_i[1] & (b_i == '0);
               dbz_flag_d = 1'b0;
               if (op_i[1]) begin
                  opnd_d = b_abs;
                  // Divide by zero parks |a| in the remainder half so FIX restores a_i.
                  acc_d  = (b_i == '0) ? {a_abs, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, a_abs};
               end else begin
                  opnd_d = a_abs;
                  acc_d  = {{WIDTH{1'b0}}, b_abs};
               end
            end
         end
         RUN: begin
            if (dbz_q || (cnt_q == '0)) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
               acc_d = is_div_q ? div_next : mul_next;
            end
         end
         FIX: begin
            state_d = DONE;
            if (dbz_q) begin
               hi_d       = rem_fix;
               lo_d       = {WIDTH{1'b1}};
               dbz_flag_d = 1'b1;
            end else if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         dbz_q      <= 1'b0;
         dbz_flag_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         is_div_q   <= is_div_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         dbz_q      <= dbz_d;
         dbz_flag_q <= dbz_flag_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign busy_o        = (state_q == RUN) || (state_q == FIX);
   assign done_o        = (state_q == DONE);
   assign hi_o          = hi_q;
   assign lo_o          = lo_q;
   assign div_by_zero_o = dbz_flag_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected results queued at issue, compared on done.
module tb_mul_div_unit;
   import mdu_pkg::*;

   localparam int unsigned W = 32;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          start_i = 1'b0;
   logic [1:0]    op_i = 2'b00;
   logic [W-1:0]  a_i = '0;
   logic [W-1:0]  b_i = '0;
   logic          busy_o, done_o, div_by_zero_o;
   logic [W-1:0]  hi_o, lo_o;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
      .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o),
      .div_by_zero_o(div_by_zero_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model built on the simulator's own 64-bit arithmetic.
   function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      exp_t e;
      logic signed [63:0] sa, sb, r64;
      logic [63:0] u64;
      sa    = {{32{a[31]}}, a};
      sb    = {{32{b[31]}}, b};
      e.dbz = 1'b0;
      case (op)
         MDU_MULTU: begin u64 = {32'b0, a} * {32'b0, b}; {e.hi, e.lo} = u64; end
         MDU_MULT:  begin r64 = sa * sb; {e.hi, e.lo} = r64; end
         default: begin
            if (b == '0) begin
               e.hi = a; e.lo = '1; e.dbz = 1'b1;
            end else if (op == MDU_DIVU) begin
               e.lo = a / b; e.hi = a % b;
            end else begin
               r64 = sa / sb; e.lo = r64[31:0];
               r64 = sa % sb; e.hi = r64[31:0];
            end
         end
      endcase
      return e;
   endfunction

   always @(negedge clk_i) begin
      if (done_o === 1'b1) begin
         if (sb_q.size() == 0) begin
            check_eq("unexpected_done", 64'(done_o), 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check_eq("res_hi", 64'(hi_o), 64'(mon_e.hi));
            check_eq("res_lo", 64'(lo_o), 64'(mon_e.lo));
            check_eq("res_dbz", 64'(div_by_zero_o), 64'(mon_e.dbz));
         end
      end
   end

   task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int rst_at, input bit poke_done);
      logic [W-1:0] ph, pl;
      int lat, n;
      bit seen;
      lat = (op[1] && b == '0) ? 2 : W + 2;
      ph  = hi_o;
      pl  = lo_o;
      op_i = op; a_i = a; b_i = b; start_i = 1'b1;
      if (rst_at == 0) sb_q.push_back(model(op, a, b));
      @(posedge clk_i); #1;
      // Scramble inputs to prove the operands were latched.
      start_i = 1'b0; op_i = ~op; a_i = $urandom; b_i = $urandom;
      check_eq({tag, "_busy_e0"}, 64'(busy_o), 64'd1);
      n = 0; seen = 0;
      while (!seen && n < 100) begin
         if (n == 9 && rst_at == 0 && lat > 10) start_i = 1'b1;
         @(posedge clk_i); #1;
         n++;
         start_i = 1'b0;
         if (n == rst_at) begin
            rst_ni = 1'b0; #1;
            check_eq({tag, "_rst_busy"}, 64'(busy_o), 64'd0);
            check_eq({tag, "_rst_done"}, 64'(done_o), 64'd0);
            check_eq({tag, "_rst_hi"}, 64'(hi_o), 64'd0);
            check_eq({tag, "_rst_lo"}, 64'(lo_o), 64'd0);
            repeat (3) @(posedge clk_i);
            #1 rst_ni = 1'b1;
            @(posedge clk_i); #1;
            return;
         end
         if (n == 1) begin
            check_eq({tag, "_hold_hi"}, 64'(hi_o), 64'(ph));
            check_eq({tag, "_hold_lo"}, 64'(lo_o), 64'(pl));
            check_eq({tag, "_dbz_clr"}, 64'(div_by_zero_o), 64'd0);
         end
         if (n == W + 1 && lat > 2) check_eq({tag, "_busy_last"}, 64'(busy_o), 64'd1);
         if (done_o) seen = 1;
      end
      check_eq({tag, "_latency"}, 64'(n), 64'(lat));
      if (poke_done) begin
         start_i = 1'b1; op_i = MDU_MULTU; a_i = 32'd1; b_i = 32'd1;
      end
      @(posedge clk_i); #1;
      start_i = 1'b0;
      check_eq({tag, "_done_pulse"}, 64'(done_o), 64'd0);
      check_eq({tag, "_idle"}, 64'(busy_o), 64'd0);
   endtask

   initial begin
      logic [1:0] rop;
      logic [W-1:0] ra, rb;
      repeat (2) @(posedge clk_i);
      #1;
      check_eq("reset_busy", 64'(busy_o), 64'd0);
      check_eq("reset_done", 64'(done_o), 64'd0);
      check_eq("reset_hi", 64'(hi_o), 64'd0);
      check_eq("reset_lo", 64'(lo_o), 64'd0);
      check_eq("reset_dbz", 64'(div_by_zero_o), 64'd0);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      check_eq("multu_max_hi", 64'(hi_o), 64'hFFFF_FFFE);
      check_eq("multu_max_lo", 64'(lo_o), 64'h0000_0001);
      run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 0, 1);
      check_eq("mult_neg_hi", 64'(hi_o), 64'hFFFF_FFFF);
      check_eq("mult_neg_lo", 64'(lo_o), 64'hFFFF_FFEB);
      run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
      check_eq("div_neg_lo", 64'(lo_o), 64'hFFFF_FFFD);
      check_eq("div_neg_hi", 64'(hi_o), 64'hFFFF_FFFF);
      run_op("divu", MDU_DIVU, 32'd100, 32'd7, 0, 0);
      check_eq("divu_lo", 64'(lo_o), 64'd14);
      check_eq("divu_hi", 64'(hi_o), 64'd2);
      run_op("divu_zero", MDU_DIVU, 32'h64, 32'h0, 0, 0);
      check_eq("divu_zero_flag", 64'(div_by_zero_o), 64'd1);
      check_eq("divu_zero_hi", 64'(hi_o), 64'h64);
      check_eq("divu_zero_lo", 64'(lo_o), 64'hFFFF_FFFF);
      run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      check_eq("div_ovf_lo", 64'(lo_o), 64'h8000_0000);
      check_eq("div_ovf_hi", 64'(hi_o), 64'd0);
      check_eq("div_ovf_flag", 64'(div_by_zero_o), 64'd0);
      run_op("div_zero_neg", MDU_DIV, 32'hFFFF_FF00, 32'h0, 0, 0);
      check_eq("div_zero_neg_hi", 64'(hi_o), 64'hFFFF_FF00);
      run_op("multu_busy_start", MDU_MULTU, 32'd5, 32'd6, 0, 1);
      check_eq("multu_busy_hi", 64'(hi_o), 64'd0);
      check_eq("multu_busy_lo", 64'(lo_o), 64'd30);
      run_op("rst_mid", MDU_MULT, 32'd123, 32'd456, 15, 0);

      for (int i = 0; i < 8; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         run_op("rand", rop, ra, rb, 0, 0);
      end

      check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
